// File: rtl/fb_pkg.sv
// Shared constants, types and palette expansion for the framebuffer scan-out path.
// Default geometry is 1280x720@60 (1650x750 totals).
package fb_pkg;

  localparam int H_ACTIVE  = 1280;
  localparam int H_FP      = 110;
  localparam int H_SYNC    = 40;
  localparam int H_BP      = 220;
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 1650
  localparam int V_ACTIVE  = 720;
  localparam int V_FP      = 5;
  localparam int V_SYNC    = 5;
  localparam int V_BP      = 20;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 750
  localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;              // 921600

  localparam int RD_LAT = 2;
  localparam int ADDR_W = 20;
  localparam int CID_W  = 6;
  localparam int BAR_W  = 160;
  localparam int N_BARS = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } ctrl_t;

  // Replicate the top two ID bits into the low bits so 0 -> 0x00 and 63 -> 0xFF.
  function automatic rgb24_t cid_to_rgb(input logic [CID_W-1:0] cid, input logic sel);
    rgb24_t     rgb;
    logic [7:0] e;
    e = {cid, cid[CID_W-1 -: 2]};
    rgb.r = e;
    rgb.g = sel ? (e >> 1) : e;
    rgb.b = sel ? 8'h00 : e;
    return rgb;
  endfunction

  // Bar index by threshold comparison against multiples of BAR_W.
  function automatic logic [2:0] bar_of(input int h);
    logic [2:0] idx;
    idx = '0;
    for (int k = 1; k < N_BARS; k++) begin
      if (h >= k * BAR_W) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters and combinational active/sync/frame-start decode for one pixel clock.
module video_timing_gen #(
  parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int H_FP     = fb_pkg::H_FP,
  parameter int H_SYNC   = fb_pkg::H_SYNC,
  parameter int H_BP     = fb_pkg::H_BP,
  parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
  parameter int V_FP     = fb_pkg::V_FP,
  parameter int V_SYNC   = fb_pkg::V_SYNC,
  parameter int V_BP     = fb_pkg::V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hs,
  output logic          vs,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_last;
  logic v_last;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign active      = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hs          = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs          = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: raster timing, read address generation, sync alignment and palette.
// Optional macro FB_SCANOUT_TESTPAT_EN adds an 8-bar test pattern selected by tp_en.
module fb_scanout #(
  parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int H_FP     = fb_pkg::H_FP,
  parameter int H_SYNC   = fb_pkg::H_SYNC,
  parameter int H_BP     = fb_pkg::H_BP,
  parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
  parameter int V_FP     = fb_pkg::V_FP,
  parameter int V_SYNC   = fb_pkg::V_SYNC,
  parameter int V_BP     = fb_pkg::V_BP,
  parameter int RD_LAT   = fb_pkg::RD_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      rd_en,
  output logic [fb_pkg::ADDR_W-1:0] rd_addr,
  input  logic [fb_pkg::CID_W-1:0]  rd_data,
  input  logic                      color_sel,
  input  logic                      tp_en,
  output logic [7:0]                vid_r,
  output logic [7:0]                vid_g,
  output logic [7:0]                vid_b,
  output logic                      vid_hs,
  output logic                      vid_vs,
  output logic                      vid_de,
  output logic                      frame_start
);
  import fb_pkg::*;

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              active;
  logic              hs;
  logic              vs;
  logic              fs;
  logic              frame_end;
  logic [ADDR_W-1:0] addr_cnt;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .hs         (hs),
    .vs         (vs),
    .frame_start(fs)
  );

  assign frame_end = (h_cnt == HW'(HT - 1)) && (v_cnt == VW'(VT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= '0;
    end else if (frame_end) begin
      addr_cnt <= '0;
    end else if (active) begin
      addr_cnt <= addr_cnt + ADDR_W'(1);
    end
  end

  // pipe[0] is stage 1 (alongside rd_en); pipe[RD_LAT] lines up with rd_data.
  ctrl_t ctrl_now;
  ctrl_t pipe [RD_LAT+1];

  assign ctrl_now = '{de: active, hs: hs, vs: vs, fs: fs};

  // NOTE: the delay line is reset explicitly so syncs never replay stale state after a mid-frame reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
    end else begin
      rd_en   <= active;
      rd_addr <= addr_cnt;
      pipe[0] <= ctrl_now;
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

`ifdef FB_SCANOUT_TESTPAT_EN
  logic [2:0] bar_pipe [RD_LAT+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) bar_pipe[i] <= '0;
    end else begin
      bar_pipe[0] <= bar_of(int'(h_cnt));
      for (int i = 1; i <= RD_LAT; i++) bar_pipe[i] <= bar_pipe[i-1];
    end
  end
`else
  logic unused_tp;
  assign unused_tp = tp_en;
`endif

  rgb24_t pix;

  // NOTE: pix gets a full default first so no path through this block can infer a latch.
  always_comb begin
    pix = cid_to_rgb(rd_data, color_sel);
`ifdef FB_SCANOUT_TESTPAT_EN
    if (tp_en) begin
      pix.r = {8{bar_pipe[RD_LAT][2]}};
      pix.g = {8{bar_pipe[RD_LAT][1]}};
      pix.b = {8{bar_pipe[RD_LAT][0]}};
    end
`endif
    if (!pipe[RD_LAT].de) pix = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_r       <= '0;
      vid_g       <= '0;
      vid_b       <= '0;
      vid_de      <= 1'b0;
      vid_hs      <= 1'b0;
      vid_vs      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vid_r       <= pix.r;
      vid_g       <= pix.g;
      vid_b       <= pix.b;
      vid_de      <= pipe[RD_LAT].de;
      vid_hs      <= pipe[RD_LAT].hs;
      vid_vs      <= pipe[RD_LAT].vs;
      frame_start <= pipe[RD_LAT].fs;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout on a reduced 320x6 raster (357x13 totals) with RD_LAT=2.
// Framebuffer model returns colour ID = rd_addr[5:0] exactly RD_LAT cycles after rd_en.
module tb_fb_scanout;

  localparam int HA = 320, HFP = 11, HS = 4, HBP = 22;
  localparam int VA = 6, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;  // 357
  localparam int VT = VA + VFP + VS + VBP;  // 13
  localparam int FRAME = HT * VT;           // 4641
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en;
  logic [19:0] rd_addr;
  logic [5:0]  rd_data;
  logic        color_sel = 1'b0;
  logic        tp_en = 1'b0;
  logic [7:0]  vid_r, vid_g, vid_b;
  logic        vid_hs, vid_vs, vid_de, frame_start;

  always #5 clk = ~clk;

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .RD_LAT(LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .color_sel  (color_sel),
    .tp_en      (tp_en),
    .vid_r      (vid_r),
    .vid_g      (vid_g),
    .vid_b      (vid_b),
    .vid_hs     (vid_hs),
    .vid_vs     (vid_vs),
    .vid_de     (vid_de),
    .frame_start(frame_start)
  );

  // Framebuffer read model; 6'h2A marks data that belongs to no read.
  logic [5:0] bram_q [LAT];
  always @(posedge clk) begin
    bram_q[0] <= rd_en ? rd_addr[5:0] : 6'h2A;
    for (int i = 1; i < LAT; i++) bram_q[i] <= bram_q[i-1];
  end
  assign rd_data = bram_q[LAT-1];

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor of whole-frame properties during the first frame after release.
  bit mon_en = 0;
  int rd_pulses = 0, de_line0 = 0, hs_len = 0, vs_len = 0;
  int de_fall = 0, hs_rise = 0, vs_rise = 0, fs_n = 0;
  int fs_t [2];
  bit de_q = 0, hs_q = 0, vs_q = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_en && cyc >= 1 && cyc <= FRAME) rd_pulses++;
      if (vid_de && cyc <= HT + 3) de_line0++;
      if (vid_hs && cyc <= HT + 3) hs_len++;
      if (vid_vs && cyc <= FRAME + 4) vs_len++;
      if (frame_start && fs_n < 2) begin
        fs_t[fs_n] = cyc;
        fs_n++;
      end
      if (!vid_de && de_q && de_fall == 0) de_fall = cyc;
      if (vid_hs && !hs_q && hs_rise == 0) hs_rise = cyc;
      if (vid_vs && !vs_q && vs_rise == 0) vs_rise = cyc;
      de_q = vid_de;
      hs_q = vid_hs;
      vs_q = vid_vs;
    end
  end

  // k = clock edges since reset release; outputs sampled at the following negedge.
  typedef struct {
    int          k;
    bit          sel;
    bit          rd_en;
    int          addr;
    bit          de;
    bit          hs;
    bit          vs;
    bit          fs;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int k, input bit sel, input bit re, input int addr,
                     input bit de, input bit hs, input bit vs, input bit fs, input logic [23:0] rgb);
    vec_t v;
    v = '{k: k, sel: sel, rd_en: re, addr: addr, de: de, hs: hs, vs: vs, fs: fs, rgb: rgb};
    vecs.push_back(v);
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rd_en"}, rd_en, 0);
    check({tag, " rd_addr"}, rd_addr, 0);
    check({tag, " rgb"}, {vid_r, vid_g, vid_b}, 0);
    check({tag, " syncs"}, {vid_de, vid_hs, vid_vs, frame_start}, 0);
  endtask

  task automatic apply(input vec_t v);
    string t;
    goto(v.k - 1);
    color_sel = v.sel;
    @(negedge clk);
    t = $sformatf("k%0d", v.k);
    check({t, " rd_en"}, rd_en, v.rd_en);
    check({t, " rd_addr"}, rd_addr, v.addr);
    check({t, " de"}, vid_de, v.de);
    check({t, " hs"}, vid_hs, v.hs);
    check({t, " vs"}, vid_vs, v.vs);
    check({t, " frame_start"}, frame_start, v.fs);
    check({t, " rgb"}, {vid_r, vid_g, vid_b}, v.rgb);
  endtask

`ifdef FB_SCANOUT_TESTPAT_EN
  localparam logic [23:0] TP_A = 24'h000000, TP_B = 24'h000000, TP_C = 24'h0000FF, TP_D = 24'h0000FF;
`else
  localparam logic [23:0] TP_A = 24'h282828, TP_B = 24'h7D7D7D, TP_C = 24'h828282, TP_D = 24'hFFFFFF;
`endif

  initial begin
    //   k     sel re addr  de hs vs fs rgb
    add(1,    0, 1, 0,    0, 0, 0, 0, 24'h000000);
    add(3,    0, 1, 2,    0, 0, 0, 0, 24'h000000);
    add(4,    0, 1, 3,    1, 0, 0, 1, 24'h000000);
    add(5,    0, 1, 4,    1, 0, 0, 0, 24'h040404);
    add(27,   0, 1, 26,   1, 0, 0, 0, 24'h5D5D5D);
    add(66,   1, 1, 65,   1, 0, 0, 0, 24'hFB7D00);
    add(67,   0, 1, 66,   1, 0, 0, 0, 24'hFFFFFF);
    add(320,  0, 1, 319,  1, 0, 0, 0, 24'hF3F3F3);
    add(321,  0, 0, 320,  1, 0, 0, 0, 24'hF7F7F7);
    add(323,  0, 0, 320,  1, 0, 0, 0, 24'hFFFFFF);
    add(324,  0, 0, 320,  0, 0, 0, 0, 24'h000000);
    add(334,  0, 0, 320,  0, 0, 0, 0, 24'h000000);
    add(335,  0, 0, 320,  0, 1, 0, 0, 24'h000000);
    add(338,  0, 0, 320,  0, 1, 0, 0, 24'h000000);
    add(339,  0, 0, 320,  0, 0, 0, 0, 24'h000000);
    add(358,  0, 1, 320,  0, 0, 0, 0, 24'h000000);
    add(384,  1, 1, 346,  1, 0, 0, 0, 24'h5D2E00);
    add(2105, 0, 1, 1919, 1, 0, 0, 0, 24'hF3F3F3);
    add(2859, 0, 0, 1920, 0, 0, 0, 0, 24'h000000);
    add(2860, 0, 0, 1920, 0, 0, 1, 0, 24'h000000);
    add(3191, 0, 0, 1920, 0, 1, 1, 0, 24'h000000);
    add(3573, 0, 0, 1920, 0, 0, 1, 0, 24'h000000);
    add(3574, 0, 0, 1920, 0, 0, 0, 0, 24'h000000);
    add(4641, 0, 0, 1920, 0, 0, 0, 0, 24'h000000);
    add(4642, 0, 1, 0,    0, 0, 0, 0, 24'h000000);
    add(4645, 0, 1, 3,    1, 0, 0, 1, 24'h000000);
    add(4646, 0, 1, 4,    1, 0, 0, 0, 24'h040404);

    repeat (3) @(negedge clk);
    check_zero("in reset");

    rst_n  = 1'b1;
    mon_en = 1;
    foreach (vecs[i]) apply(vecs[i]);

    check("rd_en pulses per frame", rd_pulses, HA * VA);
    check("de cycles on line 0", de_line0, HA);
    check("first frame_start", fs_t[0], 4);
    check("frame_start period", fs_t[1] - fs_t[0], FRAME);
    check("de fall to hs rise", hs_rise - de_fall, HFP);
    check("hs width", hs_len, HS);
    check("vs width", vs_len, VS * HT);
    check("vs start after active", vs_rise - (4 + VA * HT), VFP * HT);

    // Abort mid-line at (200,3) of the second frame.
    goto(FRAME + 3 * HT + 200);
    check("pre-abort de", vid_de, 1);
    check("pre-abort rd_addr", rd_addr, 3 * HA + 199);
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    check_zero("async reset");
    repeat (2) @(negedge clk);
    check_zero("held reset");
    rst_n = 1'b1;
    foreach (vecs[i]) if (vecs[i].k <= 400) apply(vecs[i]);

    goto(400);
    color_sel = 1'b0;
    tp_en     = 1'b1;
    goto(2 * HT + 10 + 4);
    check("tp pixel (10,2)", {vid_r, vid_g, vid_b}, TP_A);
    goto(2 * HT + 159 + 4);
    check("tp pixel (159,2)", {vid_r, vid_g, vid_b}, TP_B);
    goto(2 * HT + 160 + 4);
    check("tp pixel (160,2)", {vid_r, vid_g, vid_b}, TP_C);
    goto(2 * HT + 319 + 4);
    check("tp pixel (319,2)", {vid_r, vid_g, vid_b}, TP_D);
    tp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
